// File: rtl/escalonador_escrita_if.sv
// escalonador_escrita_if: issue-stage, write-back and register-bank signals of the write-back controller.
//   issue side : reserva, reservaReg, leitura1, leitura2 -> stall
//   port A/B   : wbX_valid, wbX_reg, wbX_data -> wbX_ready
//   bank side  : regWrite, escrita, dataWrite; status pendentes, erro
interface escalonador_escrita_if #(parameter int DATA_W = 32);
   logic              reserva;
   logic [4:0]        reservaReg;
   logic [4:0]        leitura1;
   logic [4:0]        leitura2;
   logic              stall;
   logic              wbA_valid;
   logic [4:0]        wbA_reg;
   logic [DATA_W-1:0] wbA_data;
   logic              wbA_ready;
   logic              wbB_valid;
   logic [4:0]        wbB_reg;
   logic [DATA_W-1:0] wbB_data;
   logic              wbB_ready;
   logic              regWrite;
   logic [4:0]        escrita;
   logic [DATA_W-1:0] dataWrite;
   logic [5:0]        pendentes;
   logic              erro;
   modport master (
      output reserva, reservaReg, leitura1, leitura2,
      output wbA_valid, wbA_reg, wbA_data, wbB_valid, wbB_reg, wbB_data,
      input  stall, wbA_ready, wbB_ready, regWrite, escrita, dataWrite, pendentes, erro
   );
   modport slave (
      input  reserva, reservaReg, leitura1, leitura2,
      input  wbA_valid, wbA_reg, wbA_data, wbB_valid, wbB_reg, wbB_data,
      output stall, wbA_ready, wbB_ready, regWrite, escrita, dataWrite, pendentes, erro
   );
endinterface

// File: rtl/escalonador_escrita.sv
// escalonador_escrita: shares the register bank write port between ALU (A) and load (B) write-backs,
// tracks pending destination registers and stalls issue on RAW/WAW hazards.
//   clk, rst : clock, synchronous active-high reset
//   bus      : escalonador_escrita_if.slave (issue, write-back ports, bank outputs, status)
module escalonador_escrita #(
   parameter int DATA_W       = 32,
   parameter bit PRIO_INICIAL = 1'b0
) (
   input logic                    clk,
   input logic                    rst,
   escalonador_escrita_if.slave   bus
);
   logic [31:0]       busy, busy_nxt;
   logic              ptr, stall, both, ga, gb, xfer;
   logic [4:0]        xreg;
   logic [DATA_W-1:0] xdata;
   logic [5:0]        cnt;

   // busy[0] is never set, so r0 reads and reservations cannot stall
   assign stall         = busy[bus.leitura1] | busy[bus.leitura2] | (bus.reserva & busy[bus.reservaReg]);
   assign both          = bus.wbA_valid & bus.wbB_valid;
   assign ga            = bus.wbA_valid & (!bus.wbB_valid | !ptr);
   assign gb            = bus.wbB_valid & (!bus.wbA_valid | ptr);
   assign xfer          = ga | gb;
   assign xreg          = ga ? bus.wbA_reg : bus.wbB_reg;
   assign xdata         = ga ? bus.wbA_data : bus.wbB_data;
   assign bus.stall     = stall;
   assign bus.wbA_ready = ga;
   assign bus.wbB_ready = gb;

   // clear before set: a same-edge reservation of the committed register keeps it busy
   always_comb begin
      busy_nxt = busy;
      if (xfer) busy_nxt[xreg] = 1'b0;
      if (bus.reserva && !stall) busy_nxt[bus.reservaReg] = 1'b1;
      busy_nxt[0] = 1'b0;
      cnt = '0;
      for (int i = 0; i < 32; i++) cnt = cnt + {5'd0, busy_nxt[i]};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy          <= '0;
         ptr           <= PRIO_INICIAL;
         bus.regWrite  <= 1'b0;
         bus.escrita   <= '0;
         bus.dataWrite <= '0;
         bus.pendentes <= '0;
         bus.erro      <= 1'b0;
      end else begin
         busy          <= busy_nxt;
         bus.pendentes <= cnt;
         ptr           <= ptr ^ both;
         bus.regWrite  <= xfer && (xreg != 5'd0);
         if (xfer) begin
            bus.escrita   <= xreg;
            bus.dataWrite <= xdata;
         end
         if (xfer && (xreg != 5'd0) && !busy[xreg]) bus.erro <= 1'b1;
      end
   end
endmodule

// File: tb/tb_escalonador_escrita.sv
// tb_escalonador_escrita: directed and randomized checks of escalonador_escrita against a scoreboard model.
module tb_escalonador_escrita;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;

   escalonador_escrita_if #(.DATA_W(32)) bus();
   escalonador_escrita #(.DATA_W(32), .PRIO_INICIAL(1'b0)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

   always #5 clk = ~clk;

   // reference scoreboard: set of pending registers, which port is favoured on a tie, last bank write
   bit          pend[32];
   bit          fav_b;
   bit          m_erro, m_rw;
   logic [4:0]  m_esc;
   logic [31:0] m_dat;
   bit          last_ga, last_gb;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic int npend();
      int n = 0;
      foreach (pend[i]) n += int'(pend[i]);
      return n;
   endfunction

   // one clock: check combinational outputs for the driven inputs, advance model, check registered outputs
   task automatic step();
      bit hz, a_win, b_win;
      int r;
      logic [31:0] d;
      #1;
      hz = pend[bus.leitura1] || pend[bus.leitura2] || (bus.reserva && pend[bus.reservaReg]);
      if (bus.wbA_valid && bus.wbB_valid) begin
         a_win = !fav_b;
         b_win = fav_b;
      end else begin
         a_win = bus.wbA_valid;
         b_win = bus.wbB_valid;
      end
      chk("stall", {31'd0, bus.stall}, {31'd0, hz});
      chk("wbA_ready", {31'd0, bus.wbA_ready}, {31'd0, a_win});
      chk("wbB_ready", {31'd0, bus.wbB_ready}, {31'd0, b_win});
      last_ga = a_win;
      last_gb = b_win;
      r = a_win ? int'(bus.wbA_reg) : int'(bus.wbB_reg);
      d = a_win ? bus.wbA_data : bus.wbB_data;
      @(posedge clk);
      if (rst) begin
         foreach (pend[i]) pend[i] = 1'b0;
         fav_b = 1'b0; m_erro = 1'b0; m_rw = 1'b0; m_esc = '0; m_dat = '0;
      end else begin
         m_rw = 1'b0;
         if (a_win || b_win) begin
            if (r != 0 && !pend[r]) m_erro = 1'b1;
            pend[r] = 1'b0;
            m_rw  = (r != 0);
            m_esc = 5'(r);
            m_dat = d;
         end
         if (bus.reserva && !hz && bus.reservaReg != 0) pend[bus.reservaReg] = 1'b1;
         if (bus.wbA_valid && bus.wbB_valid) fav_b = !fav_b;
      end
      #1;
      chk("regWrite", {31'd0, bus.regWrite}, {31'd0, m_rw});
      chk("escrita", {27'd0, bus.escrita}, {27'd0, m_esc});
      chk("dataWrite", bus.dataWrite, m_dat);
      chk("pendentes", {26'd0, bus.pendentes}, 32'(npend()));
      chk("erro", {31'd0, bus.erro}, {31'd0, m_erro});
   endtask

   task automatic idle();
      bus.reserva = 0; bus.reservaReg = 0; bus.leitura1 = 0; bus.leitura2 = 0;
      bus.wbA_valid = 0; bus.wbA_reg = 0; bus.wbA_data = 0;
      bus.wbB_valid = 0; bus.wbB_reg = 0; bus.wbB_data = 0;
   endtask

   task automatic reserve(input logic [4:0] r);
      bus.reserva = 1; bus.reservaReg = r;
      step();
      bus.reserva = 0;
   endtask

   initial begin
      bit       a_v, b_v;
      logic [4:0] a_r, b_r;
      logic [31:0] a_d, b_d;
      idle();
      rst = 1; step(); rst = 0;
      step();
      chk("rst_regWrite", {31'd0, bus.regWrite}, 32'd0);
      chk("rst_pendentes", {26'd0, bus.pendentes}, 32'd0);

      reserve(5);
      bus.leitura1 = 5; #1;
      chk("raw_stall_r5", {31'd0, bus.stall}, 32'd1);
      step();
      bus.leitura1 = 0;
      bus.wbA_valid = 1; bus.wbA_reg = 5; bus.wbA_data = 32'h0000_00AA;
      step();
      bus.wbA_valid = 0;
      chk("r5_escrita", {27'd0, bus.escrita}, 32'd5);
      chk("r5_data", bus.dataWrite, 32'hAA);
      chk("r5_pend", {26'd0, bus.pendentes}, 32'd0);

      reserve(3); reserve(4); reserve(6); reserve(8);
      bus.wbA_valid = 1; bus.wbA_reg = 3; bus.wbA_data = 32'h11;
      bus.wbB_valid = 1; bus.wbB_reg = 4; bus.wbB_data = 32'h22;
      step();
      chk("rr1_escrita", {27'd0, bus.escrita}, 32'd3);
      bus.wbA_reg = 6; bus.wbA_data = 32'h33;
      step();
      chk("rr2_escrita", {27'd0, bus.escrita}, 32'd4);
      bus.wbB_reg = 8; bus.wbB_data = 32'h44;
      step();
      chk("rr3_escrita", {27'd0, bus.escrita}, 32'd6);
      bus.wbA_valid = 0;
      step();
      chk("rr4_data", bus.dataWrite, 32'h44);
      bus.wbB_valid = 0;

      bus.wbB_valid = 1; bus.wbB_reg = 0; bus.wbB_data = 32'hFFFF_FFFF;
      step();
      bus.wbB_valid = 0;
      chk("r0_regWrite", {31'd0, bus.regWrite}, 32'd0);
      chk("r0_erro", {31'd0, bus.erro}, 32'd0);

      bus.wbA_valid = 1; bus.wbA_reg = 9; bus.wbA_data = 32'h99;
      step();
      bus.wbA_valid = 0;
      chk("r9_escrita", {27'd0, bus.escrita}, 32'd9);
      chk("r9_erro", {31'd0, bus.erro}, 32'd1);
      step();
      chk("erro_sticky", {31'd0, bus.erro}, 32'd1);

      reserve(7);
      bus.reserva = 1; bus.reservaReg = 7;
      bus.wbA_valid = 1; bus.wbA_reg = 7; bus.wbA_data = 32'h77;
      step();
      idle();
      chk("r7_pend", {26'd0, bus.pendentes}, 32'd0);

      bus.reserva = 1; bus.reservaReg = 11;
      bus.wbA_valid = 1; bus.wbA_reg = 11; bus.wbA_data = 32'hBB;
      step();
      idle();
      chk("setwins_pend", {26'd0, bus.pendentes}, 32'd1);

      reserve(12);
      bus.wbA_valid = 1; bus.wbA_reg = 12; bus.wbA_data = 32'hCC;
      rst = 1; step(); rst = 0;
      idle();
      chk("midrst_regWrite", {31'd0, bus.regWrite}, 32'd0);
      chk("midrst_erro", {31'd0, bus.erro}, 32'd0);
      step();

      a_v = 0; b_v = 0; a_r = 0; b_r = 0; a_d = 0; b_d = 0;
      for (int c = 0; c < 400; c++) begin
         if (!a_v && $urandom_range(0, 1) == 1) begin
            a_v = 1; a_r = 5'($urandom); a_d = $urandom;
         end
         if (!b_v && $urandom_range(0, 2) == 0) begin
            b_v = 1; b_r = 5'($urandom); b_d = $urandom;
         end
         bus.reserva = 1'($urandom); bus.reservaReg = 5'($urandom);
         bus.leitura1 = 5'($urandom); bus.leitura2 = 5'($urandom);
         bus.wbA_valid = a_v; bus.wbA_reg = a_r; bus.wbA_data = a_d;
         bus.wbB_valid = b_v; bus.wbB_reg = b_r; bus.wbB_data = b_d;
         rst = ($urandom_range(0, 99) == 0);
         step();
         if (last_ga || rst) a_v = 0;
         if (last_gb || rst) b_v = 0;
      end
      rst = 0;
      idle();
      step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
